// File: rtl/eprisc_intctl_if.sv
//------------------------------------------------------------------------------
// eprisc_intctl_if: system-bus register port of the epRISC interrupt controller | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface eprisc_intctl_if;
  logic [31:0] iAddr;
  logic [31:0] iDataIn;
  logic [31:0] oDataOut;
  logic        iWrite;
  logic        iRead;
  logic        oSel;

  modport master (
    output iAddr, iDataIn, iWrite, iRead,
    input  oDataOut, oSel
  );

  modport slave (
    input  iAddr, iDataIn, iWrite, iRead,
    output oDataOut, oSel
  );
endinterface

`default_nettype wire

// File: rtl/eprisc_intctl.sv
//------------------------------------------------------------------------------
// eprisc_intctl: N-source + NMI prioritising interrupt controller for the epRISC core | rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module eprisc_intctl #(
  parameter int          N_SOURCES = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [N_SOURCES-1:0] iIrq,
  input  logic                 iNmi,
  eprisc_intctl_if.slave       bus,
  output logic                 oMaskInt,
  output logic                 oNonMaskInt
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ASSERT    = 2'd1,
    S_INSERVICE = 2'd2
  } state_e;

  state_e               state_q;
  logic [N_SOURCES-1:0] irq_s1_q, irq_s2_q, irq_s3_q;
  logic [N_SOURCES-1:0] pending_q, pending_d;
  logic [N_SOURCES-1:0] enable_q, mode_q;
  logic                 nmi_s1_q, nmi_s2_q, nmi_s3_q;
  logic                 nmi_q, nmi_d;
  logic [4:0]           vector_q;
  logic                 mask_int_q;

  logic [31:0]          offset;
  logic [31:0]          rdata;
  logic                 sel;
  logic                 rd_vec, wr_pend, wr_en, wr_mode, wr_eoi, wr_nmi;
  logic                 ack, any_req;
  logic [N_SOURCES-1:0] req, irq_edge, ack_mask, clr_mask;
  logic [4:0]           winner;
  logic                 unused_data;

  // Unsigned offset makes addresses below BASE_ADDR wrap high and miss the map.
  assign offset  = bus.iAddr - BASE_ADDR;
  assign sel     = (offset < 32'd6);
  assign rd_vec  = sel && bus.iRead  && (offset[2:0] == 3'd0);
  assign wr_pend = sel && bus.iWrite && (offset[2:0] == 3'd1);
  assign wr_en   = sel && bus.iWrite && (offset[2:0] == 3'd2);
  assign wr_mode = sel && bus.iWrite && (offset[2:0] == 3'd3);
  assign wr_eoi  = sel && bus.iWrite && (offset[2:0] == 3'd4);
  assign wr_nmi  = sel && bus.iWrite && (offset[2:0] == 3'd5);
  assign unused_data = ^bus.iDataIn;

  assign req      = pending_q & enable_q;
  assign any_req  = |req;
  assign ack      = (state_q == S_ASSERT) && rd_vec;
  assign irq_edge = irq_s2_q & ~irq_s3_q;

  always_comb begin
    winner = '0;
    for (int i = N_SOURCES - 1; i >= 0; i--) begin
      if (req[i]) winner = 5'(i);
    end
  end

  always_comb begin
    ack_mask = '0;
    for (int i = 0; i < N_SOURCES; i++) begin
      ack_mask[i] = ack && (vector_q == 5'(i));
    end
  end

  // Clears are applied before sets so a fresh edge always survives a W1C or an ack.
  assign clr_mask  = (wr_pend ? bus.iDataIn[N_SOURCES-1:0] : '0) | ack_mask;
  assign pending_d = (mode_q & ((pending_q & ~clr_mask) | irq_edge)) | (~mode_q & irq_s2_q);
  assign nmi_d     = (nmi_q & ~(wr_nmi && bus.iDataIn[0])) | (nmi_s2_q & ~nmi_s3_q);

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset[2:0])
        3'd0:    rdata = {state_q == S_INSERVICE, state_q == S_ASSERT, 25'd0, vector_q};
        3'd1:    rdata = 32'(pending_q);
        3'd2:    rdata = 32'(enable_q);
        3'd3:    rdata = 32'(mode_q);
        3'd5:    rdata = {31'd0, nmi_q};
        default: rdata = '0;
      endcase
    end
  end

  assign bus.oDataOut = rdata;
  assign bus.oSel     = sel;
  assign oMaskInt     = mask_int_q;
  assign oNonMaskInt  = nmi_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      irq_s1_q  <= '0;
      irq_s2_q  <= '0;
      irq_s3_q  <= '0;
      nmi_s1_q  <= 1'b0;
      nmi_s2_q  <= 1'b0;
      nmi_s3_q  <= 1'b0;
      nmi_q     <= 1'b0;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
    end else begin
      irq_s1_q  <= iIrq;
      irq_s2_q  <= irq_s1_q;
      irq_s3_q  <= irq_s2_q;
      nmi_s1_q  <= iNmi;
      nmi_s2_q  <= nmi_s1_q;
      nmi_s3_q  <= nmi_s2_q;
      nmi_q     <= nmi_d;
      pending_q <= pending_d;
      if (wr_en)   enable_q <= bus.iDataIn[N_SOURCES-1:0];
      if (wr_mode) mode_q   <= bus.iDataIn[N_SOURCES-1:0];
    end
  end

  // On ack the vector is frozen at the value the core just read.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      mask_int_q <= 1'b0;
      vector_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            state_q    <= S_ASSERT;
            mask_int_q <= 1'b1;
            vector_q   <= winner;
          end
        end
        S_ASSERT: begin
          if (ack) begin
            state_q    <= S_INSERVICE;
            mask_int_q <= 1'b0;
          end else if (!any_req) begin
            state_q    <= S_IDLE;
            mask_int_q <= 1'b0;
          end else begin
            vector_q   <= winner;
          end
        end
        S_INSERVICE: begin
          if (wr_eoi) state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          mask_int_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
